// File: rtl/hps_pio_pkg.sv
// Shared register map and bit positions for the HPS multi-channel parallel input port.
package hps_pio_pkg;

    localparam int unsigned REG_CTRL       = 32'd0;
    localparam int unsigned REG_STATUS     = 32'd1;
    localparam int unsigned REG_SAMPLE_CNT = 32'd2;
    localparam int unsigned REG_SNAP_BASE  = 32'd4;

    localparam int unsigned BIT_FREEZE = 32'd0;
    localparam int unsigned BIT_IRQ_EN = 32'd1;
    localparam int unsigned BIT_NEW    = 32'd0;
    localparam int unsigned BIT_MISSED = 32'd1;

    // Sticky status bit: a set in the same cycle as a write-1-to-clear wins.
    function automatic logic w1c_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

endpackage

// File: rtl/hps_pio_snap_bank.sv
// Snapshot registers for all channels, loaded together, with a channel-indexed read port.
module hps_pio_snap_bank
    import hps_pio_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 28,
    parameter int SW  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [NCH*DW-1:0] in_port,
    input  logic [SW-1:0]     rd_sel,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] snap_q [NCH];

    // Capture every channel in the same cycle so the bank is always coherent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                snap_q[i] <= {DW{1'b0}};
            end
        end else if (load) begin
            for (int i = 0; i < NCH; i++) begin
                snap_q[i] <= in_port[i*DW +: DW];
            end
        end
    end

    // AND-OR read mux; an out-of-range index returns zero.
    always_comb begin
        rd_data = {DW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            rd_data = rd_data | ({DW{int'(rd_sel) == i}} & snap_q[i]);
        end
    end

endmodule

// File: rtl/hps_multi_pio_in.sv
// Avalon-MM slave exposing coherent snapshots of NCH input channels, a sample counter,
// sticky status flags and a level interrupt.
module hps_multi_pio_in
    import hps_pio_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 28,
    parameter int AW  = $clog2(NCH + 4)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AW-1:0]     address,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [NCH*DW-1:0] in_port,
    input  logic              in_valid,
    output logic              irq
);

    localparam int          SW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SNAP_END = REG_SNAP_BASE + NCH;

    logic [1:0]    ctrl_q, ctrl_d;
    logic [1:0]    status_q, status_d;
    logic [31:0]   sample_cnt_q, sample_cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          irq_q, irq_d;

    logic [31:0]   addr_s;
    logic          wr_ctrl_s, wr_status_s;
    logic          sample_s, missed_s;
    logic [1:0]    clr_s;
    logic          is_snap_s;
    logic [SW-1:0] snap_sel_s;
    logic [DW-1:0] snap_rd_s;
    logic          unused_wdata_s;

    assign addr_s         = 32'(address);
    assign wr_ctrl_s      = write && (addr_s == REG_CTRL);
    assign wr_status_s    = write && (addr_s == REG_STATUS);
    // FREEZE is the registered value, so an in_valid alongside a CTRL write sees the old setting.
    assign sample_s       = in_valid & ~ctrl_q[BIT_FREEZE];
    assign missed_s       = in_valid &  ctrl_q[BIT_FREEZE];
    assign is_snap_s      = (addr_s >= REG_SNAP_BASE) && (addr_s < SNAP_END);
    assign snap_sel_s     = SW'(addr_s - REG_SNAP_BASE);
    assign unused_wdata_s = ^writedata[31:2];

    hps_pio_snap_bank #(
        .NCH (NCH),
        .DW  (DW),
        .SW  (SW)
    ) u_snap_bank (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (sample_s),
        .in_port (in_port),
        .rd_sel  (snap_sel_s),
        .rd_data (snap_rd_s)
    );

    // Next-state for control, status, counter and interrupt.
    always_comb begin
        ctrl_d       = ctrl_q;
        status_d     = status_q;
        sample_cnt_d = sample_cnt_q;
        clr_s        = 2'b00;

        if (wr_ctrl_s) begin
            ctrl_d = writedata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        if (wr_status_s) begin
            clr_s = writedata[1:0];
        end else begin
            clr_s = 2'b00;
        end
        status_d[BIT_NEW]    = w1c_next(status_q[BIT_NEW], sample_s, clr_s[BIT_NEW]);
        status_d[BIT_MISSED] = w1c_next(status_q[BIT_MISSED], missed_s, clr_s[BIT_MISSED]);

        if (sample_s) begin
            sample_cnt_d = sample_cnt_q + 32'd1;
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        irq_d = status_q[BIT_NEW] & ctrl_q[BIT_IRQ_EN];
    end

    // Read mux; readdata is registered so reads have one cycle of latency and no side effects.
    always_comb begin
        readdata_d = 32'd0;
        if (addr_s == REG_CTRL) begin
            readdata_d = {30'd0, ctrl_q};
        end else if (addr_s == REG_STATUS) begin
            readdata_d = {30'd0, status_q};
        end else if (addr_s == REG_SAMPLE_CNT) begin
            readdata_d = sample_cnt_q;
        end else if (is_snap_s) begin
            readdata_d = 32'(snap_rd_s);
        end else begin
            readdata_d = 32'd0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q       <= 2'b00;
            status_q     <= 2'b00;
            sample_cnt_q <= 32'd0;
            readdata_q   <= 32'd0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            status_q     <= status_d;
            sample_cnt_q <= sample_cnt_d;
            readdata_q   <= readdata_d;
            irq_q        <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_hps_multi_pio_in.sv
// Directed, table-driven bench for hps_multi_pio_in plus two parameter-sweep instances.
module tb_hps_multi_pio_in;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;

    logic [2:0]   address = 3'd0;
    logic         write = 1'b0;
    logic [31:0]  writedata = 32'd0;
    logic [31:0]  readdata;
    logic [111:0] in_port = 112'd0;
    logic         in_valid = 1'b0;
    logic         irq;

    logic [2:0]   address_b = 3'd0;
    logic [31:0]  writedata_b = 32'd0;
    logic [31:0]  readdata_b;
    logic [0:0]   in_port_b = 1'b0;
    logic         in_valid_b = 1'b0;
    logic         irq_b;

    logic [3:0]   address_c = 4'd0;
    logic [31:0]  writedata_c = 32'd0;
    logic [31:0]  readdata_c;
    logic [255:0] in_port_c = 256'd0;
    logic         in_valid_c = 1'b0;
    logic         irq_c;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [8];

    localparam logic [111:0] D1 = {28'hFFFFFFF, 28'h0000001, 28'hABCDEF0, 28'h1234567};
    localparam logic [111:0] D2 = {28'h5555555, 28'hAAAAAAA, 28'h0F0F0F0, 28'h7654321};
    localparam logic [111:0] D3 = {28'h1111111, 28'h2222222, 28'h3333333, 28'h4444444};
    localparam logic [111:0] D4 = {28'h9999999, 28'h8888888, 28'h7777777, 28'h6666666};

    hps_multi_pio_in dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata), .in_port(in_port),
        .in_valid(in_valid), .irq(irq)
    );

    hps_multi_pio_in #(.NCH(1), .DW(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address_b), .write(1'b0),
        .writedata(writedata_b), .readdata(readdata_b), .in_port(in_port_b),
        .in_valid(in_valid_b), .irq(irq_b)
    );

    hps_multi_pio_in #(.NCH(8), .DW(32)) dut_c (
        .clk(clk), .reset_n(reset_n), .address(address_c), .write(1'b0),
        .writedata(writedata_c), .readdata(readdata_c), .in_port(in_port_c),
        .in_valid(in_valid_c), .irq(irq_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; write = 1'b1; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic pulse(input logic [111:0] d);
        @(negedge clk);
        in_port = d; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        address = a;
        @(negedge clk);
        chk(nm, readdata, exp);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].addr, tbl[i].exp, $sformatf("%s_a%0d", tag, tbl[i].addr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset, with a strobe arriving while reset is held that must be discarded.
        repeat (2) @(negedge clk);
        in_port = D2; in_valid = 1'b1;
        @(negedge clk);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) tbl[i] = '{addr: 3'(i), exp: 32'd0};
        run_table("reset");
        chk("reset_irq", {31'd0, irq}, 32'd0);

        // First sample after reset.
        pulse(D1);
        tbl[0] = '{addr: 3'd0, exp: 32'h0000_0000};
        tbl[1] = '{addr: 3'd1, exp: 32'h0000_0001};
        tbl[2] = '{addr: 3'd2, exp: 32'h0000_0001};
        tbl[3] = '{addr: 3'd3, exp: 32'h0000_0000};
        tbl[4] = '{addr: 3'd4, exp: 32'h0123_4567};
        tbl[5] = '{addr: 3'd5, exp: 32'h0ABC_DEF0};
        tbl[6] = '{addr: 3'd6, exp: 32'h0000_0001};
        tbl[7] = '{addr: 3'd7, exp: 32'h0FFF_FFFF};
        run_table("sample");

        // Counter wrap.
        @(negedge clk);
        force dut.sample_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        release dut.sample_cnt_q;
        rd(3'd2, 32'hFFFF_FFFF, "cnt_preset");
        pulse(D1);
        rd(3'd2, 32'h0000_0000, "cnt_wrap");

        // Freeze: snapshot and counter hold, MISSED sets.
        wr(3'd0, 32'd1);
        rd(3'd0, 32'd1, "ctrl_freeze");
        pulse(D2);
        rd(3'd4, 32'h0123_4567, "frz_snap0");
        rd(3'd7, 32'h0FFF_FFFF, "frz_snap3");
        rd(3'd2, 32'h0000_0000, "frz_cnt");
        rd(3'd1, 32'h0000_0003, "frz_status");
        wr(3'd0, 32'd0);
        pulse(D2);
        rd(3'd4, 32'h0765_4321, "unfrz_snap0");
        rd(3'd6, 32'h0AAA_AAAA, "unfrz_snap2");
        rd(3'd2, 32'h0000_0001, "unfrz_cnt");

        // CTRL write and in_valid together: the old FREEZE=0 applies.
        @(negedge clk);
        address = 3'd0; write = 1'b1; writedata = 32'd1; in_port = D3; in_valid = 1'b1;
        @(negedge clk);
        write = 1'b0; in_valid = 1'b0;
        rd(3'd2, 32'h0000_0002, "ctrlwr_cnt");
        rd(3'd4, 32'h0444_4444, "ctrlwr_snap0");
        rd(3'd0, 32'h0000_0001, "ctrlwr_ctrl");
        wr(3'd0, 32'd0);

        // Read of a SNAP word during an update returns the old value first.
        @(negedge clk);
        address = 3'd4; in_port = D4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("coincide_old", readdata, 32'h0444_4444);
        @(negedge clk);
        chk("coincide_new", readdata, 32'h0666_6666);

        // Write-1-to-clear and interrupt timing.
        wr(3'd1, 32'd3);
        rd(3'd1, 32'd0, "w1c_status");
        wr(3'd0, 32'd2);
        pulse(D1);
        chk("irq_t1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_t2", {31'd0, irq}, 32'd1);
        wr(3'd1, 32'd1);
        chk("irqclr_t1", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("irqclr_t2", {31'd0, irq}, 32'd0);
        pulse(D1);
        @(negedge clk);
        @(negedge clk);
        address = 3'd1; write = 1'b1; writedata = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        write = 1'b0; in_valid = 1'b0;
        chk("setwin_irq1", {31'd0, irq}, 32'd1);
        @(negedge clk);
        chk("setwin_irq2", {31'd0, irq}, 32'd1);
        chk("setwin_status", readdata, 32'd1);

        // NCH=1, DW=1: mapping, unmapped reads, exact one-cycle latency.
        @(negedge clk);
        in_port_b = 1'b1; in_valid_b = 1'b1;
        @(negedge clk);
        in_valid_b = 1'b0; address_b = 3'd3;
        @(negedge clk);
        address_b = 3'd4;
        #1;
        chk("b_lat_before", readdata_b, 32'd0);
        @(negedge clk);
        chk("b_snap0", readdata_b, 32'd1);
        for (int a = 5; a < 8; a++) begin
            address_b = 3'(a);
            @(negedge clk);
            chk($sformatf("b_unmapped_a%0d", a), readdata_b, 32'd0);
        end

        // NCH=8, DW=32: every channel lane and the unmapped tail.
        @(negedge clk);
        for (int i = 0; i < 8; i++) in_port_c[i*32 +: 32] = 32'h1020_3040 + 32'h1111_1111 * 32'(i);
        in_valid_c = 1'b1;
        @(negedge clk);
        in_valid_c = 1'b0;
        for (int a = 2; a < 16; a++) begin
            logic [31:0] e;
            address_c = 4'(a);
            @(negedge clk);
            if (a == 2) e = 32'd1;
            else if (a >= 4 && a < 12) e = 32'h1020_3040 + 32'h1111_1111 * 32'(a - 4);
            else e = 32'd0;
            chk($sformatf("c_a%0d", a), readdata_c, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
